counter_unit: RTL and testbench

COUNTER_UNIT -- requirements
Module: counter

---
 rtl/counter_unit.sv | 117 +++++++++++
 tb/tb_counter_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/counter_unit.sv
// -----------------------------------------------------------------------------
// counter_unit
//
// Free-running up/down counter. Every rising clk edge outside reset moves the
// count by STEP in the direction selected by dir. dir is sampled at the same
// edge that updates the count, so a reversal takes effect on the very next
// edge with no hold cycle. There is no enable input.
//
// Arithmetic:
//   default build          : modulo 2^WIDTH (wraps in both directions, also
//                            when STEP does not divide 2^WIDTH)
//   COUNTER_SATURATE_EN    : define this macro to clamp at 2^WIDTH-1 going
//                            up and at 0 going down instead of wrapping; a
//                            clamped counter moves again as soon as dir
//                            reverses
//
// Parameters:
//   WIDTH   : count / output width in bits (2..32)
//   STEP    : amount added or subtracted per clock (1..2^WIDTH-1)
//   RST_VAL : value loaded into the count while reset is asserted
//
// Ports:
//   clk     : in  1      rising-edge clock, single domain
//   resetn  : in  1      asynchronous reset, ACTIVE-HIGH despite the name
//                        (1 = in reset); forces the count to RST_VAL at once
//   dir     : in  1      1 = count up, 0 = count down
//   c_out   : out WIDTH  current count, driven straight from the register
// -----------------------------------------------------------------------------
module counter_unit #(
  parameter int unsigned        WIDTH   = 8,
  parameter int unsigned        STEP    = 1,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             dir,
  output logic [WIDTH-1:0] c_out
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("counter_unit: WIDTH must be in 2..32");
  end

  // STEP must be nonzero and fit in WIDTH bits; shifting a 64-bit copy keeps
  // the test valid for WIDTH = 32 where 2**WIDTH would overflow an int.
  if (STEP == 0 || (64'(STEP) >> WIDTH) != 64'd0) begin : g_bad_step
    $error("counter_unit: STEP must be in 1..2^WIDTH-1");
  end

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  // ---------------------------------------------------------------------------
  // Count register
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

`ifdef COUNTER_SATURATE_EN
  // ---------------------------------------------------------------------------
  // Saturating next-count
  //
  // Both candidates are formed one bit wider than the count. The extra top
  // bit is the carry out of the addition (result exceeded 2^WIDTH-1) or the
  // borrow out of the subtraction (result went below 0); either one selects
  // the corresponding clamp value instead of the truncated sum.
  // ---------------------------------------------------------------------------
  localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

  logic [WIDTH:0] sum_x;
  logic [WIDTH:0] diff_x;

  // NOTE: every signal assigned in an always_comb gets a value on every path
  //       (here via the defaults at the top), otherwise a latch is inferred.
  always_comb begin
    sum_x   = {1'b0, count_q} + STEP_X;
    diff_x  = {1'b0, count_q} - STEP_X;
    count_d = count_q;
    if (dir) begin
      count_d = sum_x[WIDTH]  ? {WIDTH{1'b1}} : sum_x[WIDTH-1:0];
    end else begin
      count_d = diff_x[WIDTH] ? {WIDTH{1'b0}} : diff_x[WIDTH-1:0];
    end
  end
`else
  // ---------------------------------------------------------------------------
  // Wrapping next-count
  //
  // WIDTH-bit arithmetic discards the carry/borrow, which is exactly modulo
  // 2^WIDTH for any STEP, including steps that do not divide 2^WIDTH.
  // ---------------------------------------------------------------------------
  always_comb begin
    count_d = count_q;
    if (dir) begin
      count_d = count_q + STEP_W;
    end else begin
      count_d = count_q - STEP_W;
    end
  end
`endif

  // NOTE: sequential state is written with non-blocking (<=) assignments so
  //       every flop samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      count_q <= RST_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  // Output comes straight off the flop: no combinational path from dir.
  assign c_out = count_q;

endmodule

// File: tb/tb_counter_unit.sv
// -----------------------------------------------------------------------------
// tb_counter_unit
//
// Self-checking bench for counter_unit. Three instances share clk, resetn and
// dir:
//   dut_a : WIDTH=8, STEP=1, RST_VAL=0     (directed sequences + random)
//   dut_b : WIDTH=4, STEP=3, RST_VAL=0     (non-dividing step wrap)
//   dut_c : WIDTH=5, STEP=7, RST_VAL=13    (non-zero reset value)
// A reference model computes each next count from plain integer arithmetic
// (modulo or clamp, depending on COUNTER_SATURATE_EN) and is compared against
// every instance one time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_counter_unit;

  logic       clk = 1'b0;
  logic       resetn;
  logic       dir;
  logic [7:0] c_out_a;
  logic [3:0] c_out_b;
  logic [4:0] c_out_c;

  int n_cmp = 0;
  int n_err = 0;

  longint model_a;
  longint model_b;
  longint model_c;

  always #5 clk = ~clk;

  counter_unit #(.WIDTH(8), .STEP(1), .RST_VAL(8'd0)) dut_a (
    .clk(clk), .resetn(resetn), .dir(dir), .c_out(c_out_a)
  );

  counter_unit #(.WIDTH(4), .STEP(3), .RST_VAL(4'd0)) dut_b (
    .clk(clk), .resetn(resetn), .dir(dir), .c_out(c_out_b)
  );

  counter_unit #(.WIDTH(5), .STEP(7), .RST_VAL(5'd13)) dut_c (
    .clk(clk), .resetn(resetn), .dir(dir), .c_out(c_out_c)
  );

  // ---------------------------------------------------------------------------
  // Checking and reference model
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint ref_next(longint c, bit up, int w, longint s);
    longint m;
    m = longint'(1) << w;
`ifdef COUNTER_SATURATE_EN
    if (up) return (c + s > m - 1) ? m - 1 : c + s;
    else    return (c < s) ? 0 : c - s;
`else
    if (up) return (c + s) % m;
    else    return (c - s + m) % m;
`endif
  endfunction

  task automatic reset_models();
    model_a = 0;
    model_b = 0;
    model_c = 13;
  endtask

  task automatic check_all(input string tag);
    check({tag, "/a"}, 64'(c_out_a), 64'(model_a));
    check({tag, "/b"}, 64'(c_out_b), 64'(model_b));
    check({tag, "/c"}, 64'(c_out_c), 64'(model_c));
  endtask

  // One clock: advance the model with the dir value present at the edge,
  // then compare away from the edge.
  task automatic tick(input string tag);
    @(posedge clk);
    if (!resetn) begin
      model_a = ref_next(model_a, dir, 8, 1);
      model_b = ref_next(model_b, dir, 4, 3);
      model_c = ref_next(model_c, dir, 5, 7);
    end
    #1;
    check_all(tag);
  endtask

  // Assert reset between edges and confirm it lands before the next edge.
  task automatic async_reset(input string tag);
    #2;
    resetn = 1'b1;
    reset_models();
    #1;
    check_all(tag);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int seq_b [8];
    seq_b = '{0, 3, 6, 9, 12, 15, 2, 5};

    // Power-up reset with no clock edge yet: must act asynchronously.
    resetn = 1'b0;
    dir    = 1'b0;
    #1;
    resetn = 1'b1;
    reset_models();
    #1;
    check_all("por");

    // Held in reset for 7 clocks with dir=0.
    for (int i = 0; i < 7; i++) tick("in_reset");
    check("in_reset_const", 64'(c_out_a), 64'h00);

    // Release; count down for 400 clocks.
    resetn = 1'b0;
    tick("down_first");
`ifdef COUNTER_SATURATE_EN
    check("down_first_const", 64'(c_out_a), 64'h00);
`else
    check("down_first_const", 64'(c_out_a), 64'hFF);
`endif
    for (int i = 1; i < 400; i++) tick("down");
`ifdef COUNTER_SATURATE_EN
    check("down_400_const", 64'(c_out_a), 64'h00);
`else
    check("down_400_const", 64'(c_out_a), 64'h70);
`endif

    // Count up for 400 clocks.
    dir = 1'b1;
    for (int i = 0; i < 400; i++) tick("up");
`ifdef COUNTER_SATURATE_EN
    check("up_400_const", 64'(c_out_a), 64'hFF);
    dir = 1'b0;
    tick("sat_reverse");
    check("sat_reverse_const", 64'(c_out_a), 64'hFE);
`else
    check("up_400_const", 64'(c_out_a), 64'h00);
`endif

    // Mid-count asynchronous reset, held for a few clocks with varying dir.
    for (int i = 0; i < 20; i++) begin
      dir = 1'($urandom_range(0, 1));
      tick("pre_async");
    end
    async_reset("async_mid");
    check("async_mid_const", 64'(c_out_c), 64'd13);
    for (int i = 0; i < 3; i++) begin
      dir = 1'($urandom_range(0, 1));
      tick("async_hold");
    end

    // Count up from 0: STEP=3 WIDTH=4 sequence, then reach 0x40 on dut_a.
    dir    = 1'b1;
    resetn = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      tick("up_from_0");
`ifndef COUNTER_SATURATE_EN
      if (k < 8) check("step3_seq", 64'(c_out_b), 64'(seq_b[k]));
`endif
    end
    check("reach_40", 64'(c_out_a), 64'h40);

    // Toggle dir every clock from 0x40: 0x41, 0x40, 0x41, ...
    for (int i = 0; i < 16; i++) begin
      dir = (i % 2 == 0);
      tick("toggle");
      check("toggle_const", 64'(c_out_a), (i % 2 == 0) ? 64'h41 : 64'h40);
    end

    // Random direction with occasional asynchronous resets.
    for (int i = 0; i < 2000; i++) begin
      dir = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) == 0) begin
        async_reset("rand_async");
        for (int j = 0; j < int'($urandom_range(1, 3)); j++) tick("rand_hold");
        resetn = 1'b0;
      end
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
